regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Sits between the write-back stage and a register file that has only one write port.
- Accepts up to two register writes per cycle from write-back (e.g. popl: %esp update plus the loaded value) and queues them in program order.
- Drains one write per cycle onto the single register-file write port.
- Provides stall back-pressure, plus a pending-write lookup so decode can bypass values not yet committed.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  write-back presents a request this cycle.
- wb_write1  in  1  port-1 write enable.
- wb_reg1  in  4  port-1 register ID.
- wb_value1  in  32  port-1 data.
- wb_write2  in  1  port-2 write enable.
- wb_reg2  in  4  port-2 register ID.
- wb_value2  in  32  port-2 data.
- wb_ready  out  1  arbiter can accept a request this cycle.
- rf_write  out  1  register-file write enable, registered.
- rf_reg  out  4  register-file write address, registered.
- rf_value  out  32  register-file write data, registered.
- lookup_reg_a  in  4  decode source A register ID.
- lookup_hit_a  out  1  a pending write to lookup_reg_a exists.
- lookup_value_a  out  32  youngest pending value for lookup_reg_a.
- lookup_reg_b  in  4  decode source B register ID.
- lookup_hit_b  out  1  a pending write to lookup_reg_b exists.
- lookup_value_b  out  32  youngest pending value for lookup_reg_b.
- pending_count  out  PTR_W+1  number of occupied queue entries.

Behaviour:
- Reset (synchronous): head=0, tail=0, count=0, rf_write=0, rf_reg=0, rf_value=0. Queue contents become don't-care and all entries invalid.
  - Reset mid-operation discards every pending write; no rf_write pulse follows.
  - wb_valid is ignored in any cycle where reset=1.
- wb_ready = (DEPTH - count >= 2), combinational from registered count only.
  - It never depends on wb_* inputs.
  - A request is accepted only when wb_valid and wb_ready are both high.
- Enqueue on an accepted request, at the clock edge:
  - A port is a "live write" if its enable=1 and its reg != 4'hF (RNONE). Writes to RNONE are dropped silently and never occupy a slot.
  - Port 1 is enqueued at tail, then port 2 at the next slot, so port 2 is younger.
  - 0, 1 or 2 entries are added. Same-register writes on both ports are both queued; port 2 commits last and wins.
- Dequeue every cycle when count>0 (before this edge's enqueue): rf_write<=1, rf_reg/rf_value<=head entry, head advances.
  - When count==0: rf_write<=0, and rf_reg/rf_value hold their last value.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n.
  - The dequeue reads the pre-edge head, so a write accepted at edge N is presented on rf_* at the earliest after edge N+1.
  - Minimum latency is 2 edges from accept to rf_write high.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH, guaranteed by the wb_ready rule. Empty: count==0. Full: count==DEPTH.
- Lookup (combinational, per port):
  - Candidates are all valid queue entries plus the rf_* output register when rf_write=1.
  - Priority is youngest first: the newest queue entry (tail-1 backward to head), then the rf_* register.
  - hit=1 with that value on the first match.
  - If there is no match, or the lookup reg is 4'hF: hit=0, value=0.
  - Lookup never reflects same-cycle wb_* inputs.
- Throughput: sustained one write per cycle. Two-write requests back-to-back fill the queue, and wb_ready drops until drained.

Test Plan:
- Reset, then wb_valid with write1 only (reg 3, 0x11) -> accepted at edge 1. After edge 2: rf_write=1, rf_reg=3, rf_value=0x11. After edge 3: rf_write=0. pending_count 0->1->0.
- Single request, write1 (reg 4, 0xA0) + write2 (reg 0, 0xB0) -> rf writes reg 4 then reg 0 on consecutive cycles. A same-reg variant (reg 2: 0x1, then 0x2) commits 0x1 then 0x2.
- DEPTH=4, two-write requests held valid every cycle -> wb_ready falls when count>2. No write is lost or reordered; the sequence on rf_* matches the request order exactly.
- Request with wb_reg2=4'hF and write2=1 -> only port 1 is queued; pending_count increments by 1.
- Queue holds reg 5=0x10 (older) then reg 5=0x20; lookup_reg_a=5 -> hit_a=1, value_a=0x20. After both drain -> hit_a=0, value_a=0. A lookup of reg 5 while only rf_* holds reg 5 -> hit from the output register.
- Three pending entries, reset asserted for one cycle -> rf_write=0, pending_count=0, and no further rf_write until new requests arrive.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - dual-issue write-back queue draining onto a single register-file write port
// Port 2 of a request is always younger than port 1; lookups search youngest-first, ending at the rf_* register.
module regfile_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic             wb_write1,
  input  logic [3:0]       wb_reg1,
  input  logic [31:0]      wb_value1,
  input  logic             wb_write2,
  input  logic [3:0]       wb_reg2,
  input  logic [31:0]      wb_value2,
  output logic             wb_ready,
  output logic             rf_write,
  output logic [3:0]       rf_reg,
  output logic [31:0]      rf_value,
  input  logic [3:0]       lookup_reg_a,
  output logic             lookup_hit_a,
  output logic [31:0]      lookup_value_a,
  input  logic [3:0]       lookup_reg_b,
  output logic             lookup_hit_b,
  output logic [31:0]      lookup_value_b,
  output logic [PTR_W:0]   pending_count
);

  localparam logic [3:0]     RNONE     = 4'hF;
  localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - 2);

  logic [3:0]       ent_reg_q [DEPTH];
  logic [31:0]      ent_val_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, slot2;
  logic [PTR_W:0]   count_q, count_d, enq_n, deq_n;
  logic             rf_write_q, rf_write_d;
  logic [3:0]       rf_reg_q, rf_reg_d;
  logic [31:0]      rf_value_q, rf_value_d;
  logic             accept, live1, live2, deq;

  // Two free slots are always demanded so a request never has to be split.
  assign wb_ready      = (count_q <= READY_MAX);
  assign accept        = wb_valid && wb_ready && !reset;
  assign live1         = accept && wb_write1 && (wb_reg1 != RNONE);
  assign live2         = accept && wb_write2 && (wb_reg2 != RNONE);
  assign deq           = (count_q != '0);
  assign slot2         = live1 ? tail_q + PTR_W'(1) : tail_q;

  assign rf_write      = rf_write_q;
  assign rf_reg        = rf_reg_q;
  assign rf_value      = rf_value_q;
  assign pending_count = count_q;

  always_comb begin
    enq_n      = (PTR_W + 1)'(live1) + (PTR_W + 1)'(live2);
    deq_n      = (PTR_W + 1)'(deq);
    count_d    = count_q + enq_n - deq_n;
    tail_d     = tail_q + enq_n[PTR_W-1:0];
    head_d     = deq ? head_q + PTR_W'(1) : head_q;
    rf_write_d = deq;
    rf_reg_d   = rf_reg_q;
    rf_value_d = rf_value_q;
    if (deq) begin
      rf_reg_d   = ent_reg_q[head_q];
      rf_value_d = ent_val_q[head_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_write_q <= 1'b0;
      rf_reg_q   <= '0;
      rf_value_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_write_q <= rf_write_d;
      rf_reg_q   <= rf_reg_d;
      rf_value_q <= rf_value_d;
    end
  end

  always_ff @(posedge clock) begin
    if (live1) begin
      ent_reg_q[tail_q] <= wb_reg1;
      ent_val_q[tail_q] <= wb_value1;
    end
    if (live2) begin
      ent_reg_q[slot2] <= wb_reg2;
      ent_val_q[slot2] <= wb_value2;
    end
  end

  // Walk oldest to youngest so the last match wins; the rf_* register is older than any entry.
  function automatic logic [32:0] lookup(input logic [3:0] r);
    logic [32:0]      res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (r != RNONE) begin
      if (rf_write_q && (rf_reg_q == r)) res = {1'b1, rf_value_q};
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if (((PTR_W + 1)'(i) < count_q) && (ent_reg_q[idx] == r)) res = {1'b1, ent_val_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {lookup_hit_a, lookup_value_a} = lookup(lookup_reg_a);
    {lookup_hit_b, lookup_value_b} = lookup(lookup_reg_b);
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector table plus back-pressure and reset sequences
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, wb_write1, wb_write2;
  logic [3:0]  wb_reg1, wb_reg2;
  logic [31:0] wb_value1, wb_value2;
  logic        wb_ready, rf_write;
  logic [3:0]  rf_reg;
  logic [31:0] rf_value;
  logic [3:0]  lookup_reg_a, lookup_reg_b;
  logic        lookup_hit_a, lookup_hit_b;
  logic [31:0] lookup_value_a, lookup_value_b;
  logic [2:0]  pending_count;

  regfile_write_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid),
    .wb_write1(wb_write1), .wb_reg1(wb_reg1), .wb_value1(wb_value1),
    .wb_write2(wb_write2), .wb_reg2(wb_reg2), .wb_value2(wb_value2),
    .wb_ready(wb_ready),
    .rf_write(rf_write), .rf_reg(rf_reg), .rf_value(rf_value),
    .lookup_reg_a(lookup_reg_a), .lookup_hit_a(lookup_hit_a), .lookup_value_a(lookup_value_a),
    .lookup_reg_b(lookup_reg_b), .lookup_hit_b(lookup_hit_b), .lookup_value_b(lookup_value_b),
    .pending_count(pending_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid, w1;
    logic [3:0]  r1;
    logic [31:0] v1;
    logic        w2;
    logic [3:0]  r2;
    logic [31:0] v2;
    logic [3:0]  la, lb;
    logic        e_ready, e_rfw;
    logic [3:0]  e_rfr;
    logic [31:0] e_rfv;
    logic        e_ha;
    logic [31:0] e_va;
    logic        e_hb;
    logic [31:0] e_vb;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", name, n_vec, act, exp);
    end
  endtask

  task automatic add(input logic valid, input logic w1, input logic [3:0] r1, input logic [31:0] v1,
                     input logic w2, input logic [3:0] r2, input logic [31:0] v2,
                     input logic [3:0] la, input logic [3:0] lb,
                     input logic e_ready, input logic e_rfw, input logic [3:0] e_rfr, input logic [31:0] e_rfv,
                     input logic e_ha, input logic [31:0] e_va, input logic e_hb, input logic [31:0] e_vb,
                     input logic [2:0] e_cnt);
    vec_t v;
    v.valid = valid; v.w1 = w1; v.r1 = r1; v.v1 = v1; v.w2 = w2; v.r2 = r2; v.v2 = v2;
    v.la = la; v.lb = lb; v.e_ready = e_ready; v.e_rfw = e_rfw; v.e_rfr = e_rfr; v.e_rfv = e_rfv;
    v.e_ha = e_ha; v.e_va = e_va; v.e_hb = e_hb; v.e_vb = e_vb; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic valid, input logic w1, input logic [3:0] r1, input logic [31:0] v1,
                       input logic w2, input logic [3:0] r2, input logic [31:0] v2);
    wb_valid = valid; wb_write1 = w1; wb_reg1 = r1; wb_value1 = v1;
    wb_write2 = w2; wb_reg2 = r2; wb_value2 = v2;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [35:0] sb[$];
  logic [35:0] exp_e;
  int          mcount;
  logic        mdeq, acc;
  int          next_id;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    lookup_reg_a = 4'hF;
    lookup_reg_b = 4'hF;

    // Rows: inputs held this cycle | outputs expected before the next edge
    add(1'b1,1'b1,4'h3,32'h11,1'b0,4'h0,32'h0, 4'h3,4'hF, 1'b1,1'b0,4'h0,32'h0,  1'b0,32'h0, 1'b0,32'h0, 3'd0);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h3,4'hF, 1'b1,1'b0,4'h0,32'h0,  1'b1,32'h11,1'b0,32'h0, 3'd1);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h3,4'hF, 1'b1,1'b1,4'h3,32'h11, 1'b1,32'h11,1'b0,32'h0, 3'd0);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h3,4'hF, 1'b1,1'b0,4'h3,32'h11, 1'b0,32'h0, 1'b0,32'h0, 3'd0);
    add(1'b1,1'b1,4'h4,32'hA0,1'b1,4'h0,32'hB0,4'h4,4'h0, 1'b1,1'b0,4'h3,32'h11, 1'b0,32'h0, 1'b0,32'h0, 3'd0);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h4,4'h0, 1'b1,1'b0,4'h3,32'h11, 1'b1,32'hA0,1'b1,32'hB0,3'd2);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h4,4'h0, 1'b1,1'b1,4'h4,32'hA0, 1'b1,32'hA0,1'b1,32'hB0,3'd1);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h4,4'h0, 1'b1,1'b1,4'h0,32'hB0, 1'b0,32'h0, 1'b1,32'hB0,3'd0);
    add(1'b1,1'b1,4'h2,32'h1, 1'b1,4'h2,32'h2, 4'h2,4'h0, 1'b1,1'b0,4'h0,32'hB0, 1'b0,32'h0, 1'b0,32'h0, 3'd0);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h2,4'h0, 1'b1,1'b0,4'h0,32'hB0, 1'b1,32'h2, 1'b0,32'h0, 3'd2);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h2,4'h0, 1'b1,1'b1,4'h2,32'h1,  1'b1,32'h2, 1'b0,32'h0, 3'd1);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h2,4'h0, 1'b1,1'b1,4'h2,32'h2,  1'b1,32'h2, 1'b0,32'h0, 3'd0);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h2,4'h0, 1'b1,1'b0,4'h2,32'h2,  1'b0,32'h0, 1'b0,32'h0, 3'd0);
    add(1'b1,1'b1,4'h7,32'h77,1'b1,4'hF,32'h99,4'h7,4'hF, 1'b1,1'b0,4'h2,32'h2,  1'b0,32'h0, 1'b0,32'h0, 3'd0);
    add(1'b1,1'b0,4'h1,32'h5, 1'b1,4'hF,32'h6, 4'h7,4'hF, 1'b1,1'b0,4'h2,32'h2,  1'b1,32'h77,1'b0,32'h0, 3'd1);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h7,4'hF, 1'b1,1'b1,4'h7,32'h77, 1'b1,32'h77,1'b0,32'h0, 3'd0);
    add(1'b0,1'b1,4'h1,32'hEE,1'b1,4'h8,32'hEF,4'h1,4'h8, 1'b1,1'b0,4'h7,32'h77, 1'b0,32'h0, 1'b0,32'h0, 3'd0);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h1,4'h8, 1'b1,1'b0,4'h7,32'h77, 1'b0,32'h0, 1'b0,32'h0, 3'd0);
    add(1'b1,1'b1,4'h5,32'h10,1'b1,4'h6,32'h33,4'h5,4'h6, 1'b1,1'b0,4'h7,32'h77, 1'b0,32'h0, 1'b0,32'h0, 3'd0);
    add(1'b1,1'b1,4'h5,32'h20,1'b0,4'h0,32'h0, 4'h5,4'h6, 1'b1,1'b0,4'h7,32'h77, 1'b1,32'h10,1'b1,32'h33,3'd2);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h5,4'h6, 1'b1,1'b1,4'h5,32'h10, 1'b1,32'h20,1'b1,32'h33,3'd2);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h5,4'h6, 1'b1,1'b1,4'h6,32'h33, 1'b1,32'h20,1'b1,32'h33,3'd1);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h5,4'h6, 1'b1,1'b1,4'h5,32'h20, 1'b1,32'h20,1'b0,32'h0, 3'd0);
    add(1'b0,1'b0,4'h0,32'h0, 1'b0,4'h0,32'h0, 4'h5,4'h6, 1'b1,1'b0,4'h5,32'h20, 1'b0,32'h0, 1'b0,32'h0, 3'd0);

    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].valid, tbl[i].w1, tbl[i].r1, tbl[i].v1, tbl[i].w2, tbl[i].r2, tbl[i].v2);
      lookup_reg_a = tbl[i].la;
      lookup_reg_b = tbl[i].lb;
      #1;
      n_vec++;
      chk("wb_ready",       32'(wb_ready),       32'(tbl[i].e_ready));
      chk("rf_write",       32'(rf_write),       32'(tbl[i].e_rfw));
      chk("rf_reg",         32'(rf_reg),         32'(tbl[i].e_rfr));
      chk("rf_value",       rf_value,            tbl[i].e_rfv);
      chk("lookup_hit_a",   32'(lookup_hit_a),   32'(tbl[i].e_ha));
      chk("lookup_value_a", lookup_value_a,      tbl[i].e_va);
      chk("lookup_hit_b",   32'(lookup_hit_b),   32'(tbl[i].e_hb));
      chk("lookup_value_b", lookup_value_b,      tbl[i].e_vb);
      chk("pending_count",  32'(pending_count),  32'(tbl[i].e_cnt));
      step();
    end

    // Back-to-back two-write requests against an order-preserving scoreboard
    mcount  = 0;
    mdeq    = 1'b0;
    next_id = 0;
    lookup_reg_a = 4'hF;
    lookup_reg_b = 4'hF;
    for (int c = 0; c < 40; c++) begin
      if (c < 12)
        drive(1'b1, 1'b1, 4'(next_id % 15), 32'h1000 + 32'(next_id),
              1'b1, 4'((next_id + 1) % 15), 32'h1000 + 32'(next_id + 1));
      else
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      #1;
      n_vec++;
      chk("bp_wb_ready", 32'(wb_ready), 32'(mcount <= 2));
      chk("bp_pending_count", 32'(pending_count), 32'(mcount));
      chk("bp_rf_write", 32'(rf_write), 32'(mdeq));
      if (rf_write) begin
        if (sb.size() == 0) begin
          chk("bp_unexpected_write", 32'(rf_write), 32'h0);
        end else begin
          exp_e = sb.pop_front();
          chk("bp_rf_reg", 32'(rf_reg), 32'(exp_e[35:32]));
          chk("bp_rf_value", rf_value, exp_e[31:0]);
        end
      end
      acc  = wb_valid && (mcount <= 2);
      mdeq = (mcount > 0);
      if (acc) begin
        sb.push_back({wb_reg1, wb_value1});
        sb.push_back({wb_reg2, wb_value2});
        next_id += 2;
        mcount  += 2;
      end
      if (mdeq) mcount--;
      step();
    end
    n_vec++;
    chk("bp_all_drained", 32'(sb.size()), 32'h0);
    chk("bp_writes_accepted", 32'(next_id >= 14), 32'h1);

    // Reset with three writes pending discards them all
    drive(1'b1, 1'b1, 4'h9, 32'h91, 1'b1, 4'hA, 32'hA1);
    step();
    drive(1'b1, 1'b1, 4'hB, 32'hB1, 1'b1, 4'hC, 32'hC1);
    step();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    lookup_reg_a = 4'hA;
    lookup_reg_b = 4'hC;
    #1;
    n_vec++;
    chk("pre_reset_count", 32'(pending_count), 32'h3);
    chk("pre_reset_rf_reg", 32'(rf_reg), 32'h9);
    chk("pre_reset_hit_b", 32'(lookup_hit_b), 32'h1);
    reset = 1'b1;
    drive(1'b1, 1'b1, 4'hD, 32'hD1, 1'b0, 4'h0, 32'h0);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      chk("post_reset_rf_write", 32'(rf_write), 32'h0);
      chk("post_reset_count", 32'(pending_count), 32'h0);
      chk("post_reset_ready", 32'(wb_ready), 32'h1);
      chk("post_reset_rf_reg", 32'(rf_reg), 32'h0);
      chk("post_reset_rf_value", rf_value, 32'h0);
      chk("post_reset_hit_a", 32'(lookup_hit_a), 32'h0);
      chk("post_reset_hit_b", 32'(lookup_hit_b), 32'h0);
      step();
    end

    // Fresh request after reset commits with the two-edge latency
    drive(1'b1, 1'b1, 4'h3, 32'h5, 1'b0, 4'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    n_vec++;
    chk("restart_rf_write_early", 32'(rf_write), 32'h0);
    chk("restart_count", 32'(pending_count), 32'h1);
    step();
    #1;
    n_vec++;
    chk("restart_rf_write", 32'(rf_write), 32'h1);
    chk("restart_rf_reg", 32'(rf_reg), 32'h3);
    chk("restart_rf_value", rf_value, 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
